// File: rtl/sa_pkg.sv
// Shared constants and types for the SA ifmap streaming path (layer windows, array geometry, FSM states).
// Latency: n/a (package).
// Backpressure: n/a (package).
package sa_pkg;

    // Array geometry defaults shared with the systolic array itself.
    localparam int SA_ROWS_DEF   = 16;
    localparam int DATA_W_DEF    = 8;
    localparam int ADDR_W_DEF    = 10;
    localparam int DRAIN_CYC_DEF = 16;

    // Ifmap SRAM windows per layer; base + len never exceeds the address space.
    localparam int CONV1_BASE = 0;
    localparam int CONV1_LEN  = 784;
    localparam int CONV2_BASE = 784;
    localparam int CONV2_LEN  = 196;

    typedef enum logic [1:0] {
        DS_IDLE   = 2'd0,
        DS_STREAM = 2'd1,
        DS_DRAIN  = 2'd2
    } dsetup_state_t;

    // Drain counter value at which conv_done fires. The counter reads 0 in the
    // cycle after the last read, so the pulse lands rows+drain+1 cycles after it.
    function automatic int drain_done_idx(input int rows, input int drain);
        return rows + drain;
    endfunction

endpackage

// File: rtl/sa_data_setup_if.sv
// Bundle between SA controller / ifmap SRAM (master side) and the data-setup block (slave side).
// Latency: n/a (wiring only).
// Backpressure: data_enable_i is the only flow control; the slave reads only while it is high.
interface sa_data_setup_if #(
    parameter int SA_ROWS = sa_pkg::SA_ROWS_DEF,
    parameter int DATA_W  = sa_pkg::DATA_W_DEF,
    parameter int ADDR_W  = sa_pkg::ADDR_W_DEF
);
    logic                      data_enable_i;
    logic [1:0]                nth_conv_i;
    logic                      rd_en_o;
    logic [ADDR_W-1:0]         rd_addr_o;
    logic [SA_ROWS*DATA_W-1:0] rd_data_i;
    logic [SA_ROWS*DATA_W-1:0] a_data_o;
    logic [SA_ROWS-1:0]        a_valid_o;
    logic                      data_last_o;
    logic                      conv_done_o;

    // Controller + SRAM + array side.
    modport master (
        output data_enable_i, nth_conv_i, rd_data_i,
        input  rd_en_o, rd_addr_o, a_data_o, a_valid_o, data_last_o, conv_done_o
    );

    // Data-setup block.
    modport slave (
        input  data_enable_i, nth_conv_i, rd_data_i,
        output rd_en_o, rd_addr_o, a_data_o, a_valid_o, data_last_o, conv_done_o
    );
endinterface

// File: rtl/sa_skew_buf.sv
// Triangular delay line: row r of the input vector leaves r cycles later, row 0 passes straight through.
// Latency: 0 cycles for row 0, r cycles for row r.
// Backpressure: none; a free-running shift, invalid slots carry data 0 / valid 0.
// Ports: clk, rst_n, in_vld/in_dat (one vector per cycle), out_vld/out_dat (per-row skewed).
module sa_skew_buf #(
    parameter int SA_ROWS = 16,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_vld,
    input  logic [SA_ROWS*DATA_W-1:0] in_dat,
    output logic [SA_ROWS-1:0]        out_vld,
    output logic [SA_ROWS*DATA_W-1:0] out_dat
);

    // Row 0 is combinational; invalid slots are forced to zero.
    assign out_vld[0]          = in_vld;
    assign out_dat[DATA_W-1:0] = in_vld ? in_dat[DATA_W-1:0] : '0;

    for (genvar r = 1; r < SA_ROWS; r++) begin : g_row
        logic [DATA_W-1:0] dat_q [0:r-1];
        logic [DATA_W-1:0] dat_d [0:r-1];
        logic              vld_q [0:r-1];
        logic              vld_d [0:r-1];

        // Data is masked on entry so the whole chain only ever holds zeros in invalid slots.
        always_comb begin
            dat_d[0] = in_vld ? in_dat[r*DATA_W +: DATA_W] : '0;
            vld_d[0] = in_vld;
            for (int s = 1; s < r; s++) begin
                dat_d[s] = dat_q[s-1];
                vld_d[s] = vld_q[s-1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < r; s++) begin
                    dat_q[s] <= '0;
                    vld_q[s] <= 1'b0;
                end
            end else begin
                for (int s = 0; s < r; s++) begin
                    dat_q[s] <= dat_d[s];
                    vld_q[s] <= vld_d[s];
                end
            end
        end

        assign out_vld[r]                  = vld_q[r-1];
        assign out_dat[r*DATA_W +: DATA_W] = dat_q[r-1];
    end

endmodule

// File: rtl/sa_data_setup.sv
// Streams one layer's ifmap vectors from SRAM into the SA west edge with diagonal skew; reports data_last/conv_done.
// Latency: read issued in the enable cycle; row r reaches the array r+1 cycles later; conv_done SA_ROWS+DRAIN_CYC+1 after last read.
// Backpressure: data_enable_i low in STREAM stalls reads (address held); enable ignored during drain.
// Ports: clk, rst_n, bus (sa_data_setup_if.slave), optional stall_cnt_o when DSETUP_STALL_CNT_EN is defined.
module sa_data_setup
    import sa_pkg::*;
#(
    parameter int SA_ROWS   = SA_ROWS_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    sa_data_setup_if.slave bus
`ifdef DSETUP_STALL_CNT_EN
    ,
    output logic [15:0]    stall_cnt_o
`endif
);

    localparam int DONE_IDX = drain_done_idx(SA_ROWS, DRAIN_CYC);
    localparam int DC_W     = $clog2(DONE_IDX + 1);

    localparam logic [DC_W-1:0]   DONE_AT   = DC_W'(DONE_IDX);
    localparam logic [ADDR_W-1:0] C1_BASE   = ADDR_W'(CONV1_BASE);
    localparam logic [ADDR_W-1:0] C2_BASE   = ADDR_W'(CONV2_BASE);
    localparam logic [ADDR_W:0]   C1_LAST   = (ADDR_W+1)'(CONV1_LEN - 1);
    localparam logic [ADDR_W:0]   C2_LAST   = (ADDR_W+1)'(CONV2_LEN - 1);

    dsetup_state_t     state_q, state_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [DC_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic              layer_q, layer_d;     // 1 = CONV2
    logic              rd_vld_q, rd_vld_d;   // SRAM data valid this cycle
`ifdef DSETUP_STALL_CNT_EN
    logic [15:0]       stall_cnt_q, stall_cnt_d;
`endif

    logic              use_conv2;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   last_idx;
    logic [ADDR_W-1:0] cnt_eff;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              data_last;
    logic              conv_done;

    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        drain_cnt_d = drain_cnt_q;
        layer_d     = layer_q;
`ifdef DSETUP_STALL_CNT_EN
        stall_cnt_d = stall_cnt_q;
`endif
        rd_en       = 1'b0;
        rd_addr     = '0;
        data_last   = 1'b0;
        conv_done   = 1'b0;

        // In IDLE the layer comes straight from the request so the first read
        // can issue in the same cycle as the enable.
        use_conv2 = (state_q == DS_IDLE) ? (bus.nth_conv_i != 2'b00) : layer_q;
        base      = use_conv2 ? C2_BASE : C1_BASE;
        last_idx  = use_conv2 ? C2_LAST : C1_LAST;
        cnt_eff   = (state_q == DS_IDLE) ? '0 : rd_cnt_q;

        unique case (state_q)
            DS_IDLE: begin
                if (bus.data_enable_i) begin
                    rd_en   = 1'b1;
                    layer_d = use_conv2;
`ifdef DSETUP_STALL_CNT_EN
                    stall_cnt_d = '0;
`endif
                end
            end
            DS_STREAM: begin
                rd_en = bus.data_enable_i;
`ifdef DSETUP_STALL_CNT_EN
                if (!bus.data_enable_i && (stall_cnt_q != 16'hFFFF)) begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                end
`endif
            end
            DS_DRAIN: begin
                if (drain_cnt_q == DONE_AT) begin
                    conv_done = 1'b1;
                    state_d   = DS_IDLE;
                    rd_cnt_d  = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: state_d = DS_IDLE;
        endcase

        // Shared read-issue path for IDLE and STREAM; the final read moves to DRAIN
        // so no address past the window is ever presented.
        if (rd_en) begin
            rd_addr  = base + cnt_eff;
            rd_cnt_d = cnt_eff + 1'b1;
            if ({1'b0, cnt_eff} == last_idx) begin
                data_last   = 1'b1;
                state_d     = DS_DRAIN;
                drain_cnt_d = '0;
            end else begin
                state_d = DS_STREAM;
            end
        end

        rd_vld_d = rd_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DS_IDLE;
            rd_cnt_q    <= '0;
            drain_cnt_q <= '0;
            layer_q     <= 1'b0;
            rd_vld_q    <= 1'b0;
`ifdef DSETUP_STALL_CNT_EN
            stall_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            layer_q     <= layer_d;
            rd_vld_q    <= rd_vld_d;
`ifdef DSETUP_STALL_CNT_EN
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

    assign bus.rd_en_o     = rd_en;
    assign bus.rd_addr_o   = rd_addr;
    assign bus.data_last_o = data_last;
    assign bus.conv_done_o = conv_done;
`ifdef DSETUP_STALL_CNT_EN
    assign stall_cnt_o     = stall_cnt_q;
`endif

    sa_skew_buf #(
        .SA_ROWS (SA_ROWS),
        .DATA_W  (DATA_W)
    ) u_skew (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (rd_vld_q),
        .in_dat  (bus.rd_data_i),
        .out_vld (bus.a_valid_o),
        .out_dat (bus.a_data_o)
    );

endmodule

// File: tb/tb_sa_data_setup.sv
module tb_sa_data_setup;

    localparam int SA_ROWS   = 16;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 10;
    localparam int DRAIN_CYC = 16;
    localparam int VW        = SA_ROWS * DATA_W;
    localparam int SLOTS     = 64;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    int   done_seen;

    sa_data_setup_if #(.SA_ROWS(SA_ROWS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

`ifdef DSETUP_STALL_CNT_EN
    logic [15:0] stall_cnt_o;
`endif

    sa_data_setup #(
        .SA_ROWS   (SA_ROWS),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus)
`ifdef DSETUP_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    typedef struct {
        int addr;
        int cyc;
        bit last;
    } rd_exp_t;

    rd_exp_t           exp_rd[$];
    int                done_q[$];
    logic [VW-1:0]     exp_dat [SLOTS];
    logic [SA_ROWS-1:0] exp_vld [SLOTS];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // SRAM contents: vector 0 has row r = r+1, everything else a fixed scramble.
    function automatic logic [VW-1:0] mem_vec(input int a);
        logic [VW-1:0] v;
        for (int r = 0; r < SA_ROWS; r++) begin
            if (a == 0) v[r*DATA_W +: DATA_W] = DATA_W'(r + 1);
            else        v[r*DATA_W +: DATA_W] = DATA_W'(a * 37 + r * 11 + (a >> 4) + 1);
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic clear_slots();
        for (int s = 0; s < SLOTS; s++) begin
            exp_dat[s] = '0;
            exp_vld[s] = '0;
        end
    endtask

    // SRAM model: data for a read seen in cycle t is presented throughout cycle t+1;
    // junk is driven otherwise so the skew masking is exercised.
    initial begin
        logic       pend_en;
        logic [ADDR_W-1:0] pend_addr;
        bus.rd_data_i = '0;
        forever begin
            @(negedge clk);
            pend_en   = bus.rd_en_o;
            pend_addr = bus.rd_addr_o;
            @(posedge clk);
            #1;
            if (pend_en) bus.rd_data_i = mem_vec(int'(pend_addr));
            else         bus.rd_data_i = {4{$urandom}};
        end
    end

    // Monitor: compares every output each cycle against what the stimulus side predicted.
    initial begin
        rd_exp_t       e;
        bit            rd_exp;
        bit            dn_exp;
        int            slot;
        int            s;
        logic [VW-1:0] v;
        forever begin
            @(negedge clk);
            slot = cyc % SLOTS;
            check("a_valid", 128'(bus.a_valid_o), 128'(exp_vld[slot]));
            check("a_data", 128'(bus.a_data_o), 128'(exp_dat[slot]));
            exp_vld[slot] = '0;
            exp_dat[slot] = '0;

            rd_exp = (exp_rd.size() > 0) && (exp_rd[0].cyc == cyc);
            e = '{addr: 0, cyc: 0, last: 1'b0};
            if (rd_exp) e = exp_rd.pop_front();
            check("rd_en", 128'(bus.rd_en_o), 128'(rd_exp));
            if (rd_exp && bus.rd_en_o) check("rd_addr", 128'(bus.rd_addr_o), 128'(e.addr));
            check("data_last", 128'(bus.data_last_o), 128'(rd_exp && e.last));
            if (bus.rd_en_o) begin
                v = mem_vec(int'(bus.rd_addr_o));
                for (int r = 0; r < SA_ROWS; r++) begin
                    s = (cyc + 1 + r) % SLOTS;
                    exp_vld[s][r] = 1'b1;
                    exp_dat[s][r*DATA_W +: DATA_W] = v[r*DATA_W +: DATA_W];
                end
            end

            dn_exp = (done_q.size() > 0) && (done_q[0] == cyc);
            if (dn_exp) void'(done_q.pop_front());
            if (bus.conv_done_o) done_seen++;
            check("conv_done", 128'(bus.conv_done_o), 128'(dn_exp));
        end
    end

    // mode 0: enable always high while reading; 1: random stalls; 2: stall on cycles 10..14.
    // abort_at >= 0 asserts reset just before that read would issue.
    task automatic run_job(input bit conv2, input int mode, input int abort_at);
        int len, addr, rem, c0, last_c, done_c, stalls, nread;
        bit en;
        len    = conv2 ? 196 : 784;
        addr   = conv2 ? 784 : 0;
        rem    = len;
        stalls = 0;
        nread  = 0;
        last_c = 0;
        bus.nth_conv_i = conv2 ? 2'($urandom_range(1, 3)) : 2'd0;
        @(posedge clk);
        #1;
        c0 = cyc;
        while (rem > 0) begin
            if (abort_at >= 0 && nread == abort_at) begin
                rst_n = 1'b0;
                bus.data_enable_i = 1'b0;
                clear_slots();
                #1;
                check("abort_rd_en", 128'(bus.rd_en_o), 128'(0));
                check("abort_rd_addr", 128'(bus.rd_addr_o), 128'(0));
                check("abort_a_valid", 128'(bus.a_valid_o), 128'(0));
                check("abort_a_data", 128'(bus.a_data_o), 128'(0));
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
`ifdef DSETUP_STALL_CNT_EN
            if (cyc == c0 + 1) check("stall_cnt_clear", 128'(stall_cnt_o), 128'(0));
`endif
            if (cyc == c0)       en = 1'b1;
            else if (mode == 1)  en = ($urandom_range(0, 9) != 0);
            else if (mode == 2)  en = !((cyc - c0 >= 10) && (cyc - c0 <= 14));
            else                 en = 1'b1;
            bus.data_enable_i = en;
            if (en) begin
                exp_rd.push_back('{addr: addr, cyc: cyc, last: (rem == 1)});
                addr++;
                rem--;
                nread++;
                last_c = cyc;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
            if (cyc > c0 + 1) bus.nth_conv_i = 2'($urandom);
        end
        done_c = last_c + SA_ROWS + DRAIN_CYC + 1;
        done_q.push_back(done_c);
        // Enable and layer select are don't-care through drain and the done cycle.
        while (cyc <= done_c) begin
            bus.data_enable_i = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.nth_conv_i    = 2'($urandom);
            @(posedge clk);
            #1;
        end
        bus.data_enable_i = 1'b0;
`ifdef DSETUP_STALL_CNT_EN
        check("stall_cnt", 128'(stall_cnt_o), 128'(stalls));
`endif
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
    endtask

    initial begin
        int seen0;
        checks    = 0;
        errors    = 0;
        done_seen = 0;
        clear_slots();
        rst_n = 1'b0;
        bus.data_enable_i = 1'b0;
        bus.nth_conv_i    = 2'd1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_en", 128'(bus.rd_en_o), 128'(0));
        check("rst_rd_addr", 128'(bus.rd_addr_o), 128'(0));
        check("rst_a_valid", 128'(bus.a_valid_o), 128'(0));
        check("rst_a_data", 128'(bus.a_data_o), 128'(0));
        check("rst_data_last", 128'(bus.data_last_o), 128'(0));
        check("rst_conv_done", 128'(bus.conv_done_o), 128'(0));
`ifdef DSETUP_STALL_CNT_EN
        check("rst_stall_cnt", 128'(stall_cnt_o), 128'(0));
`endif
        rst_n = 1'b1;

        run_job(1'b0, 0, -1);   // CONV1, enable held high
        run_job(1'b1, 1, -1);   // CONV2, random stalls
        run_job(1'b0, 2, -1);   // CONV1, 5-cycle stall window
        seen0 = done_seen;
        run_job(1'b0, 1, 100);  // CONV1 aborted by reset at read 100
        repeat (50) @(posedge clk);
        #1;
        check("no_done_after_abort", 128'(done_seen), 128'(seen0));
        run_job(1'b0, 1, -1);   // restart from base after abort
        run_job(1'b1, 1, -1);
        repeat (5) @(posedge clk);
        #1;
        check("done_count", 128'(done_seen), 128'(seen0 + 2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
